// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV64I load/store front end for a 64-bit word-addressed data
//               memory without byte enables. Loads extract and extend the
//               addressed lane; sub-word stores use read-modify-write.
//               Illegal, misaligned and out-of-range requests are answered
//               directly without a memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_WORDS   = 128,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        resp_range,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [63:0] mem_read_data
);

  // Size of the addressable byte range; requests at or above it are faults.
  localparam logic [63:0] C_MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched request fields
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;

  // Result registers presented during the response cycle
  logic [63:0] r_merged;
  logic [63:0] r_rdata;
  logic        r_misaligned;
  logic        r_illegal;
  logic        r_range;

  // Request decode (evaluated on the live request while idle)
  logic        w_accept;
  logic        w_req_illegal;
  logic        w_req_misaligned;
  logic        w_req_range;
  logic        w_flag_illegal;
  logic        w_flag_misaligned;
  logic        w_flag_range;
  logic        w_fault;

  // Lane datapath (operates on the latched request)
  logic [5:0]  w_shift;
  logic [63:0] w_lane_raw;
  logic [63:0] w_load_ext;
  logic [63:0] w_size_mask;
  logic [63:0] w_lane_mask;
  logic [63:0] w_merged;
  logic [63:0] w_word_addr;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Classify the incoming request; flags are mutually exclusive by priority.
  always_comb begin
    w_req_illegal    = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
    w_req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd0:    w_req_misaligned = 1'b0;
      2'd1:    w_req_misaligned = req_addr[0];
      2'd2:    w_req_misaligned = |req_addr[1:0];
      default: w_req_misaligned = |req_addr[2:0];
    endcase
    w_req_range       = CHECK_RANGE && (req_addr >= C_MEM_BYTES);
    w_flag_illegal    = w_req_illegal;
    w_flag_misaligned = !w_req_illegal && w_req_misaligned;
    w_flag_range      = !w_req_illegal && !w_req_misaligned && w_req_range;
    w_fault           = w_flag_illegal || w_flag_misaligned || w_flag_range;
  end

  assign w_shift     = {r_addr[2:0], 3'b000};
  assign w_lane_raw  = mem_read_data >> w_shift;
  assign w_word_addr = {r_addr[63:3], 3'b000};

  // Extract the addressed lane and sign- or zero-extend it to 64 bits.
  always_comb begin
    w_load_ext = 64'd0;
    case (r_funct3)
      3'b000:  w_load_ext = {{56{w_lane_raw[7]}},  w_lane_raw[7:0]};
      3'b001:  w_load_ext = {{48{w_lane_raw[15]}}, w_lane_raw[15:0]};
      3'b010:  w_load_ext = {{32{w_lane_raw[31]}}, w_lane_raw[31:0]};
      3'b011:  w_load_ext = w_lane_raw;
      3'b100:  w_load_ext = {56'd0, w_lane_raw[7:0]};
      3'b101:  w_load_ext = {48'd0, w_lane_raw[15:0]};
      3'b110:  w_load_ext = {32'd0, w_lane_raw[31:0]};
      default: w_load_ext = 64'd0;
    endcase
  end

  // Build the store word: memory bytes outside the lane, store bytes inside.
  always_comb begin
    w_size_mask = 64'd0;
    case (r_funct3[1:0])
      2'd0:    w_size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    w_size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_size_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    w_lane_mask = w_size_mask << w_shift;
    w_merged    = (mem_read_data & ~w_lane_mask) | ((r_wdata & w_size_mask) << w_shift);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; faults skip memory and respond immediately.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault) begin
            w_next_state = S_RESP;
          end else if (!req_store) begin
            w_next_state = S_LOAD;
          end else if (req_funct3[1:0] == 2'd3) begin
            w_next_state = S_WRITE;
          end else begin
            w_next_state = S_READ;
          end
        end
      end
      S_LOAD:  w_next_state = S_RESP;
      S_READ:  w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Memory and handshake outputs; reset suppresses strobes in the same cycle
  // so an interrupted read-modify-write never reaches memory.
  always_comb begin
    req_ready      = (r_state == S_IDLE);
    resp_valid     = 1'b0;
    mem_address    = 64'd0;
    mem_write_data = 64'd0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_LOAD, S_READ: begin
          mem_read_en = 1'b1;
          mem_address = w_word_addr;
        end
        S_WRITE: begin
          mem_write_en   = 1'b1;
          mem_address    = w_word_addr;
          mem_write_data = (r_funct3[1:0] == 2'd3) ? r_wdata : r_merged;
        end
        S_RESP: begin
          resp_valid = 1'b1;
        end
        default: begin
          resp_valid = 1'b0;
        end
      endcase
    end
  end

  // Capture the request and its fault classification on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3     <= 3'd0;
      r_addr       <= 64'd0;
      r_wdata      <= 64'd0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_range      <= 1'b0;
    end else if (w_accept) begin
      r_funct3     <= req_funct3;
      r_addr       <= req_addr;
      r_wdata      <= req_wdata;
      r_misaligned <= w_flag_misaligned;
      r_illegal    <= w_flag_illegal;
      r_range      <= w_flag_range;
    end
  end

  // Load result and RMW merge word; result clears on each new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= 64'd0;
      r_merged <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rdata  <= 64'd0;
            r_merged <= 64'd0;
          end
        end
        S_LOAD:  r_rdata  <= w_load_ext;
        S_READ:  r_merged <= w_merged;
        default: r_rdata  <= r_rdata;
      endcase
    end
  end

  assign resp_rdata      = r_rdata;
  assign resp_misaligned = r_misaligned;
  assign resp_illegal    = r_illegal;
  assign resp_range      = r_range;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit; a byte-array model
//               predicts results, flags, latency and memory traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic        resp_range;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [63:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  // Environment memory seen by the DUT
  logic [63:0] mem [0:127];
  // Reference model: flat byte array, little-endian
  logic [7:0]  ref_bytes [0:1023];

  load_store_unit #(.MEM_WORDS(128), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .resp_range(resp_range), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[9:3]];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[9:3]] <= mem_write_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] w = 64'd0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_bytes[idx*8 + i];
    return w;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [2:0] f3);
    int n = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[int'(addr[9:0]) + i];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  // Issue one request and check response, flags, latency and memory traffic.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd);
    int n = 1 << f3[1:0];
    logic ill, mis, rng;
    logic e_ill, e_mis, e_rng;
    logic [63:0] e_rdata = 64'd0;
    logic [63:0] e_wword = 64'd0;
    int e_lat, e_reads, e_writes;
    int lat_obs = 0;
    int nreads = 0;
    int nwrites = 0;
    ill = st ? f3[2] : (f3 == 3'b111);
    mis = (addr % 64'(n)) != 64'd0;
    rng = addr >= 64'd1024;
    e_ill = ill;
    e_mis = !ill && mis;
    e_rng = !ill && !mis && rng;
    rd = 64'd0;
    if (e_ill || e_mis || e_rng) begin
      e_lat = 1; e_reads = 0; e_writes = 0;
    end else if (!st) begin
      e_lat = 2; e_reads = 1; e_writes = 0;
      e_rdata = ref_load(addr, f3);
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[int'(addr[9:0]) + i] = wd[8*i +: 8];
      e_wword  = ref_word(int'(addr[9:3]));
      e_reads  = (n == 8) ? 0 : 1;
      e_writes = 1;
      e_lat    = (n == 8) ? 2 : 3;
    end

    @(negedge clk);
    check("resp_pulse_width", {63'd0, resp_valid}, 64'd0);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;

    for (int c = 1; c <= 8 && lat_obs == 0; c++) begin
      @(negedge clk);
      if (mem_read_en) begin
        nreads++;
        check("read_addr", mem_address, {addr[63:3], 3'b000});
      end
      if (mem_write_en) begin
        nwrites++;
        check("write_addr", mem_address, {addr[63:3], 3'b000});
        check("write_data", mem_write_data, e_wword);
      end
      if (!mem_read_en && !mem_write_en) check("idle_addr_zero", mem_address, 64'd0);
      if (c < e_lat) check("busy_not_ready", {63'd0, req_ready}, 64'd0);
      if (resp_valid) begin
        lat_obs = c;
        rd = resp_rdata;
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_flags", {61'd0, resp_illegal, resp_misaligned, resp_range},
              {61'd0, e_ill, e_mis, e_rng});
      end
    end
    check("latency", 64'(lat_obs), 64'(e_lat));
    check("num_reads", 64'(nreads), 64'(e_reads));
    check("num_writes", 64'(nwrites), 64'(e_writes));
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] addr, wd;
    logic [2:0]  f3;
    logic        st;
    int          n, r;

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0;
    for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'd1;
    mem[1] = 64'd2;
    for (int i = 0; i < 128; i++)
      for (int b = 0; b < 8; b++) ref_bytes[i*8 + b] = mem[i][8*b +: 8];

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_outputs", {59'd0, resp_valid, mem_read_en, mem_write_en, resp_misaligned,
          resp_illegal | resp_range}, 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_mem_address", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);

    // Directed plan
    do_req(1'b0, 3'b011, 64'h8, 64'd0, rd);
    check("ld_0x8", rd, 64'h0000_0000_0000_0002);
    do_req(1'b1, 3'b000, 64'h3, 64'hFF, rd);
    do_req(1'b0, 3'b011, 64'h0, 64'd0, rd);
    check("ld_after_sb", rd, 64'h0000_0000_FF00_0001);
    do_req(1'b0, 3'b000, 64'h3, 64'd0, rd);
    check("lb_0x3", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 3'b100, 64'h3, 64'd0, rd);
    check("lbu_0x3", rd, 64'h0000_0000_0000_00FF);
    do_req(1'b0, 3'b010, 64'h0, 64'd0, rd);
    check("lw_0x0", rd, 64'hFFFF_FFFF_FF00_0001);
    do_req(1'b0, 3'b110, 64'h0, 64'd0, rd);
    check("lwu_0x0", rd, 64'h0000_0000_FF00_0001);
    do_req(1'b0, 3'b001, 64'h1, 64'd0, rd);
    check("lh_misaligned_rdata", rd, 64'd0);
    do_req(1'b0, 3'b111, 64'h0, 64'd0, rd);
    do_req(1'b0, 3'b011, 64'h400, 64'd0, rd);

    // Reset during the WRITE cycle of a half-word RMW abandons the store
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
    req_addr = 64'h10; req_wdata = 64'hBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    @(negedge clk);
    check("rmw_read_phase", {63'd0, mem_read_en}, 64'd1);
    @(negedge clk);
    check("rmw_write_phase", {63'd0, mem_write_en}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_kills_write", {63'd0, mem_write_en}, 64'd0);
    check("rst_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_resp_after_abort", {63'd0, resp_valid}, 64'd0);
    end
    check("word2_unchanged", mem[2], ref_word(2));
    do_req(1'b0, 3'b011, 64'h10, 64'd0, rd);

    // Randomized traffic against the byte model
    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      n  = 1 << f3[1:0];
      r  = $urandom_range(0, 9);
      if (r == 0) addr = {$urandom, $urandom} | 64'h400;
      else if (r == 1) addr = 64'($urandom_range(0, 1023));
      else addr = 64'($urandom_range(0, 1023)) & ~64'(n - 1);
      wd = {$urandom, $urandom};
      do_req(st, f3, addr, wd, rd);
    end

    for (int i = 0; i < 128; i += 17) check("final_mem", mem[i], ref_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
